// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 2:1 mux datapath.
// Two requesters compete for one output channel; the owner keeps the grant for
// a burst (ended by its last flag, the MAX_BEAT limit, or dropping its request)
// and then hands over fairly, directly to the other requester when it is waiting.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   req0/req1  requester has data (level)
//   last0/1    current beat of that requester ends its burst
//   in0/in1    requester data
//   out_ready  downstream accepts the beat this cycle
//   gnt0/gnt1  registered grant, one-hot or zero
//   se1        registered mux select (0 = in0, 1 = in1)
//   out        se1 ? in1 : in0
//   out_valid  owner's request while owning, 0 in IDLE
module mux2to1_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_BEAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             last0,
  input  logic             last1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             out_ready,
  output logic             gnt0,
  output logic             gnt1,
  output logic             se1,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int unsigned CNT_W = $clog2(MAX_BEAT + 1);
  localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(MAX_BEAT);
  localparam logic [CNT_W-1:0] BEAT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             last_owner_q, last_owner_d;

  logic owning;
  logic owner_is1;
  logic owner_req;
  logic owner_last;
  logic other_req;
  logic xfer;
  logic beat_at_limit;
  logic release_done;
  logic release_drop;

  // Owner-relative view of the request/last inputs.
  always_comb begin
    owning     = (state_q != IDLE);
    owner_is1  = (state_q == OWN1);
    owner_req  = owner_is1 ? req1 : req0;
    owner_last = owner_is1 ? last1 : last0;
    other_req  = owner_is1 ? req0 : req1;
  end

  assign out_valid = owning & owner_req;
  assign out       = se1 ? in1 : in0;

  // Release conditions: burst end or beat limit on a transfer, or owner gave up.
  // A transfer carrying both last and limit is a single release.
  assign xfer          = out_valid & out_ready;
  assign beat_at_limit = xfer & (beat_cnt_q == (BEAT_LIMIT - BEAT_ONE));
  assign release_done  = xfer & (owner_last | beat_at_limit);
  assign release_drop  = owning & ~owner_req;

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (release_done || release_drop) begin
          last_owner_d = owner_is1;
          beat_cnt_d   = '0;
          if (other_req) begin
            // Direct handover, no IDLE bubble.
            state_d = owner_is1 ? OWN0 : OWN1;
          end else if (release_done) begin
            // Owner still requesting after a completed burst: re-grant.
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      last_owner_q <= 1'b1;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      se1          <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
      gnt0         <= (state_d == OWN0);
      gnt1         <= (state_d == OWN1);
      se1          <= (state_d == OWN1);
    end
  end

  // Structural invariants.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_cnt_bound:  assert property (@(posedge clk) disable iff (rst) beat_cnt_q <= BEAT_LIMIT);
  a_sel_match:  assert property (@(posedge clk) disable iff (rst) se1 == gnt1);

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Randomized scoreboard bench for mux2to1_rr_arbiter. A stimulus process drives
// each cycle, pushes the expected outputs from a behavioural ownership model and
// advances that model; a monitor pops and compares just before each rising edge.
module tb_mux2to1_rr_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned MAX_BEAT = 4;

  logic             clk;
  logic             rst;
  logic             req0, req1, last0, last1, out_ready;
  logic [WIDTH-1:0] in0, in1;
  logic             gnt0, gnt1, se1, out_valid;
  logic [WIDTH-1:0] out;

  mux2to1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEAT(MAX_BEAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .last0     (last0),
    .last1     (last1),
    .in0       (in0),
    .in1       (in1),
    .out_ready (out_ready),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .se1       (se1),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             gnt0;
    logic             gnt1;
    logic             se1;
    logic             out_valid;
    logic [WIDTH-1:0] out;
  } obs_t;

  typedef struct {
    int cycles;
    int p_req0;
    int p_req1;
    int p_last;
    int p_ready;
    int p_rst;
  } phase_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Model: who owns the channel (-1 = nobody), beats moved in this grant,
  // and who released most recently.
  int m_owner = -1;
  int m_beats = 0;
  int m_last  = 1;

  function automatic bit chance(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic step(input bit r0, input bit r1, input bit l0, input bit l1,
                      input bit rdy, input bit rs);
    bit   rq[2];
    bit   lst[2];
    obs_t e;
    int   x;
    bit   done;
    bit   reown;
    rq[0] = r0; rq[1] = r1; lst[0] = l0; lst[1] = l1;
    req0 = r0; req1 = r1; last0 = l0; last1 = l1;
    out_ready = rdy; rst = rs;
    in0 = WIDTH'($urandom);
    in1 = WIDTH'($urandom);

    e.gnt0      = (m_owner == 0);
    e.gnt1      = (m_owner == 1);
    e.se1       = (m_owner == 1);
    e.out_valid = (m_owner >= 0) && rq[m_owner];
    e.out       = (m_owner == 1) ? in1 : in0;
    sb.push_back(e);

    if (rs) begin
      m_owner = -1; m_beats = 0; m_last = 1;
    end else if (m_owner < 0) begin
      if (r0 && r1)  m_owner = 1 - m_last;
      else if (r0)   m_owner = 0;
      else if (r1)   m_owner = 1;
    end else begin
      x = m_owner; done = 1'b0; reown = 1'b0;
      if (!rq[x]) begin
        done = 1'b1;
      end else if (rdy) begin
        m_beats++;
        if (lst[x] || m_beats == MAX_BEAT) begin
          done = 1'b1; reown = 1'b1;
        end
      end
      if (done) begin
        m_last  = x;
        m_beats = 0;
        if (rq[1 - x])  m_owner = 1 - x;
        else if (reown) m_owner = x;
        else            m_owner = -1;
      end
    end
  endtask

  // Monitor: sample settled outputs 2 time units after the falling edge.
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {gnt0, gnt1, se1, out_valid, out};
        n_checks++;
        if (got === e) begin
          n_pass++;
        end else begin
          $display("FAIL cycle %0d outputs: got gnt0=%b gnt1=%b se1=%b valid=%b out=%h, want gnt0=%b gnt1=%b se1=%b valid=%b out=%h",
                   cyc, got.gnt0, got.gnt1, got.se1, got.out_valid, got.out,
                   e.gnt0, e.gnt1, e.se1, e.out_valid, e.out);
        end
      end
    end
  end

  phase_t phases[$];

  initial begin
    // cycles, p_req0, p_req1, p_last, p_ready, p_rst
    phases.push_back('{24, 100, 100,  0, 100,  0});  // tie, fixed-length bursts alternating
    phases.push_back('{30, 100, 100, 35, 100,  0});  // early burst ends
    phases.push_back('{40, 100, 100, 20,  25,  0});  // long stalls
    phases.push_back('{14, 100,   0,  0, 100,  0});  // lone requester 0 re-granted
    phases.push_back('{14,   0, 100,  0, 100,  0});  // lone requester 1 re-granted
    phases.push_back('{60, 100, 100, 10,  80, 12});  // resets mid-burst
    phases.push_back('{400, 60,  60, 25,  70,  2});  // mixed random

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    out_ready = 1'b0; in0 = '0; in1 = '0;
    repeat (2) @(posedge clk);

    foreach (phases[p]) begin
      for (int i = 0; i < phases[p].cycles; i++) begin
        @(negedge clk);
        cyc++;
        step(chance(phases[p].p_req0), chance(phases[p].p_req1),
             chance(phases[p].p_last), chance(phases[p].p_last),
             chance(phases[p].p_ready), chance(phases[p].p_rst));
      end
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
